game_flow_controller: RTL and testbench

- Top-level T-rex game sequencer.
- Gates the per-frame collision verdict from the dino/obstacle collision check, runs the IDLE/RUN/HIT/OVER game FSM, and keeps score, high score and scroll speed.
- Drives obstacle reset, scroll enable and dino freeze to the sprite/obstacle datapath.
- Sits between the VGA frame-tick source, the input synchroniser and the sprite/collision logic.

---
 rtl/game_flow_controller_pkg.sv | 28 ++
 rtl/game_flow_controller_score_counter.sv | 76 +++++++
 rtl/game_flow_controller.sv | 139 +++++++++++++
 tb/tb_game_flow_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared T-rex game constants: FSM encoding, datapath widths and default scroll speeds,
// so the sequencer, sprite, obstacle and collision blocks all agree.
package game_flow_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } game_state_e;

   localparam int SCORE_W        = 14;
   localparam int SPEED_W        = 4;
   localparam int GROUND_Y       = 400;
   localparam int SPEED_INIT_DEF = 4;
   localparam int SPEED_MAX_DEF  = 12;

   // Saturating +1 used for the displayed score.
   function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] val,
                                                        input logic [SCORE_W-1:0] max_val);
      if (val >= max_val) begin
         return max_val;
      end else begin
         return val + 14'd1;
      end
   endfunction

endpackage

// File: rtl/game_flow_controller_score_counter.sv
// Score keeper: frame divider, saturating score, speed stepping and best-score capture.
module game_flow_controller_score_counter
   import game_flow_controller_pkg::*;
#(
   parameter int SCORE_DIV      = 6,
   parameter int SPEED_INIT     = SPEED_INIT_DEF,
   parameter int SPEED_MAX      = SPEED_MAX_DEF,
   parameter int SPEED_STEP_PTS = 100,
   parameter int SCORE_MAX      = 9999
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_enable,
   input  logic               i_freeze,
   output logic [SCORE_W-1:0] o_score,
   output logic [SCORE_W-1:0] o_hi_score,
   output logic [SPEED_W-1:0] o_speed
);

   localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

   logic [DIV_W-1:0]   r_div_cnt;
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W-1:0] r_hi_score;
   logic [SPEED_W-1:0] r_speed;
   logic               w_div_wrap;
   logic               w_score_inc;
   logic               w_speed_step;
   logic [SCORE_W-1:0] w_score_next;

   // A saturated score never increments, so it can never re-trigger a speed step.
   always_comb begin
      w_div_wrap   = (r_div_cnt == DIV_W'(SCORE_DIV - 1));
      w_score_next = sat_inc_score(r_score, SCORE_W'(SCORE_MAX));
      w_score_inc  = i_enable && w_div_wrap && (w_score_next != r_score);
      w_speed_step = w_score_inc &&
                     ((w_score_next % SCORE_W'(SPEED_STEP_PTS)) == {SCORE_W{1'b0}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= {DIV_W{1'b0}};
         r_score   <= {SCORE_W{1'b0}};
         r_speed   <= SPEED_W'(SPEED_INIT);
      end else if (i_clear) begin
         r_div_cnt <= {DIV_W{1'b0}};
         r_score   <= {SCORE_W{1'b0}};
         r_speed   <= SPEED_W'(SPEED_INIT);
      end else begin
         if (i_enable) begin
            r_div_cnt <= w_div_wrap ? {DIV_W{1'b0}} : (r_div_cnt + DIV_W'(1));
         end
         if (w_score_inc) begin
            r_score <= w_score_next;
         end
         if (w_speed_step && (r_speed != SPEED_W'(SPEED_MAX))) begin
            r_speed <= r_speed + 4'd1;
         end
      end
   end

   // Best score survives restarts; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi_score <= {SCORE_W{1'b0}};
      end else if (i_freeze && (r_score > r_hi_score)) begin
         r_hi_score <= r_score;
      end
   end

   assign o_score    = r_score;
   assign o_hi_score = r_hi_score;
   assign o_speed    = r_speed;

endmodule

// File: rtl/game_flow_controller.sv
// T-rex game sequencer: IDLE/RUN/HIT/OVER FSM with start grace, restart lockout and
// the motion controls for the sprite/obstacle datapath.
module game_flow_controller
   import game_flow_controller_pkg::*;
#(
   parameter int SCORE_DIV      = 6,
   parameter int SPEED_INIT     = SPEED_INIT_DEF,
   parameter int SPEED_MAX      = SPEED_MAX_DEF,
   parameter int SPEED_STEP_PTS = 100,
   parameter int GRACE_FRAMES   = 2,
   parameter int OVER_HOLD      = 60,
   parameter int SCORE_MAX      = 9999
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               btn_jump,
   input  logic               collided,
   output logic [1:0]         game_state,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] hi_score,
   output logic [SPEED_W-1:0] speed,
   output logic               scroll_en,
   output logic               dino_freeze,
   output logic               obs_reset
);

   localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
   localparam int HOLD_W  = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

   game_state_e        r_state;
   game_state_e        w_next_state;
   logic               r_btn_prev;
   logic [GRACE_W-1:0] r_grace_cnt;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic               w_press;
   logic               w_start;
   logic               w_run_tick;
   logic               w_hit;
   logic               w_count;
   logic               w_to_over;
   logic               w_scroll_en_nxt;
   logic               w_dino_freeze_nxt;
   logic               w_obs_reset_nxt;

   // Restart beats a coincident frame tick: counters load fresh instead of decrementing.
   always_comb begin
      w_press    = btn_jump && !r_btn_prev;
      w_start    = w_press && ((r_state == ST_IDLE) ||
                               ((r_state == ST_OVER) && (r_hold_cnt == {HOLD_W{1'b0}})));
      w_run_tick = (r_state == ST_RUN) && frame_tick;
      w_hit      = w_run_tick && (r_grace_cnt == {GRACE_W{1'b0}}) && collided;
      w_count    = w_run_tick && (r_grace_cnt == {GRACE_W{1'b0}}) && !collided;
      w_to_over  = (r_state == ST_HIT) && frame_tick;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_next_state = ST_RUN;
            else         w_next_state = ST_IDLE;
         end
         ST_RUN: begin
            if (w_hit) w_next_state = ST_HIT;
            else       w_next_state = ST_RUN;
         end
         ST_HIT: begin
            if (w_to_over) w_next_state = ST_OVER;
            else           w_next_state = ST_HIT;
         end
         ST_OVER: begin
            if (w_start) w_next_state = ST_RUN;
            else         w_next_state = ST_OVER;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_scroll_en_nxt   = (w_next_state == ST_RUN);
      w_dino_freeze_nxt = (w_next_state != ST_RUN);
      w_obs_reset_nxt   = w_start;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_btn_prev  <= 1'b0;
         scroll_en   <= 1'b0;
         dino_freeze <= 1'b1;
         obs_reset   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_btn_prev  <= btn_jump;
         scroll_en   <= w_scroll_en_nxt;
         dino_freeze <= w_dino_freeze_nxt;
         obs_reset   <= w_obs_reset_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grace_cnt <= {GRACE_W{1'b0}};
         r_hold_cnt  <= {HOLD_W{1'b0}};
      end else begin
         if (w_start) begin
            r_grace_cnt <= GRACE_W'(GRACE_FRAMES);
         end else if (w_run_tick && (r_grace_cnt != {GRACE_W{1'b0}})) begin
            r_grace_cnt <= r_grace_cnt - GRACE_W'(1);
         end
         if (w_to_over) begin
            r_hold_cnt <= HOLD_W'(OVER_HOLD);
         end else if ((r_state == ST_OVER) && frame_tick && (r_hold_cnt != {HOLD_W{1'b0}})) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
         end
      end
   end

   game_flow_controller_score_counter #(
      .SCORE_DIV      (SCORE_DIV),
      .SPEED_INIT     (SPEED_INIT),
      .SPEED_MAX      (SPEED_MAX),
      .SPEED_STEP_PTS (SPEED_STEP_PTS),
      .SCORE_MAX      (SCORE_MAX)
   ) u_score_counter (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_start),
      .i_enable   (w_count),
      .i_freeze   (w_to_over),
      .o_score    (score),
      .o_hi_score (hi_score),
      .o_speed    (speed)
   );

   assign game_state = r_state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed scenarios plus random play,
// compared every cycle against an elapsed-frame-count model of the game rules.
module tb_game_flow_controller;

   localparam int SCORE_DIV  = 6;
   localparam int SPEED_INIT = 4;
   localparam int SPEED_MAX  = 12;
   localparam int STEP_PTS   = 100;
   localparam int GRACE      = 2;
   localparam int HOLD       = 60;
   localparam int SCORE_MAX  = 9999;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        btn_jump = 1'b0;
   logic        collided = 1'b0;
   logic [1:0]  game_state;
   logic [13:0] score;
   logic [13:0] hi_score;
   logic [3:0]  speed;
   logic        scroll_en;
   logic        dino_freeze;
   logic        obs_reset;

   int n_vec = 0;
   int n_err = 0;
   bit run_chk = 1'b0;

   // Model: game phase plus elapsed-frame counts; score/speed derived arithmetically.
   int m_state = 0;
   int m_eff = 0;
   int m_run_ticks = 0;
   int m_over_ticks = 0;
   int m_hi = 0;
   bit m_prev = 1'b0;
   bit m_obs = 1'b0;

   game_flow_controller #(
      .SCORE_DIV      (SCORE_DIV),
      .SPEED_INIT     (SPEED_INIT),
      .SPEED_MAX      (SPEED_MAX),
      .SPEED_STEP_PTS (STEP_PTS),
      .GRACE_FRAMES   (GRACE),
      .OVER_HOLD      (HOLD),
      .SCORE_MAX      (SCORE_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .btn_jump    (btn_jump),
      .collided    (collided),
      .game_state  (game_state),
      .score       (score),
      .hi_score    (hi_score),
      .speed       (speed),
      .scroll_en   (scroll_en),
      .dino_freeze (dino_freeze),
      .obs_reset   (obs_reset)
   );

   always #5 clk = ~clk;

   function automatic int exp_score();
      return (m_eff / SCORE_DIV > SCORE_MAX) ? SCORE_MAX : m_eff / SCORE_DIV;
   endfunction

   function automatic int exp_speed();
      int s;
      s = SPEED_INIT + exp_score() / STEP_PTS;
      return (s > SPEED_MAX) ? SPEED_MAX : s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_eff = 0; m_run_ticks = 0; m_over_ticks = 0;
      m_hi = 0; m_prev = 1'b0; m_obs = 1'b0;
   endtask

   task automatic model_start();
      m_state = 1; m_obs = 1'b1; m_eff = 0; m_run_ticks = 0;
   endtask

   task automatic model_step();
      bit press;
      press = btn_jump && !m_prev;
      m_prev = btn_jump;
      m_obs = 1'b0;
      case (m_state)
         0: if (press) model_start();
         1: if (frame_tick) begin
               m_run_ticks++;
               if (m_run_ticks > GRACE) begin
                  if (collided) m_state = 2;
                  else m_eff++;
               end
            end
         2: if (frame_tick) begin
               m_state = 3;
               m_over_ticks = 0;
               if (exp_score() > m_hi) m_hi = exp_score();
            end
         3: if (press && m_over_ticks >= HOLD) model_start();
            else if (frame_tick) m_over_ticks++;
         default: m_state = 0;
      endcase
   endtask

   // Drive one cycle of inputs; returns 1 time unit after the active edge.
   task automatic apply(input logic t, input logic b, input logic c);
      frame_tick = t; btn_jump = b; collided = c;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic frames(input int n, input logic b, input logic c);
      for (int i = 0; i < n; i++) begin
         repeat (3) apply(1'b0, b, c);
         apply(1'b1, b, c);
      end
   endtask

   task automatic goto_run();
      for (int i = 0; i < 2000 && m_state != 1; i++) begin
         if (m_state == 0 || (m_state == 3 && m_over_ticks >= HOLD)) begin
            apply(1'b0, 1'b0, 1'b0);
            apply(1'b0, 1'b1, 1'b0);
         end else begin
            apply(1'b1, 1'b0, 1'b0);
         end
      end
      chk("goto_run_state", int'(game_state), 1);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_state"}, int'(game_state), 0);
      chk({tag, "_score"}, int'(score), 0);
      chk({tag, "_hi"}, int'(hi_score), 0);
      chk({tag, "_speed"}, int'(speed), 4);
      chk({tag, "_scroll"}, int'(scroll_en), 0);
      chk({tag, "_freeze"}, int'(dino_freeze), 1);
      chk({tag, "_obs"}, int'(obs_reset), 0);
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (run_chk && !rst) begin
         chk("state", int'(game_state), m_state);
         chk("score", int'(score), exp_score());
         chk("hi_score", int'(hi_score), m_hi);
         chk("speed", int'(speed), exp_speed());
         chk("scroll_en", int'(scroll_en), (m_state == 1) ? 1 : 0);
         chk("dino_freeze", int'(dino_freeze), (m_state == 1) ? 0 : 1);
         chk("obs_reset", int'(obs_reset), int'(m_obs));
      end
   end

   initial begin
      model_reset();
      #12;
      chk_reset_values("por");
      #5 rst = 1'b0;
      run_chk = 1'b1;

      // Start on the rising edge; holding the button must not re-trigger.
      apply(1'b0, 1'b1, 1'b0);
      chk("start_state", int'(game_state), 1);
      chk("start_obs", int'(obs_reset), 1);
      apply(1'b0, 1'b1, 1'b0);
      chk("start_obs_drop", int'(obs_reset), 0);
      chk("start_speed", int'(speed), 4);
      chk("start_score", int'(score), 0);
      frames(10, 1'b1, 1'b0);
      frames(50, 1'b0, 1'b0);
      chk("score_60_ticks", int'(score), 9);
      chk("scroll_running", int'(scroll_en), 1);

      // Collision -> HIT -> OVER, best score captured.
      frames(1, 1'b0, 1'b1);
      chk("hit_state", int'(game_state), 2);
      frames(1, 1'b0, 1'b0);
      chk("over_state", int'(game_state), 3);
      chk("over_hi", int'(hi_score), 9);

      // Restart lockout, then restart coinciding with a frame tick.
      frames(30, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      chk("lockout_state", int'(game_state), 3);
      apply(1'b0, 1'b0, 1'b0);
      frames(30, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 1'b0);
      chk("restart_state", int'(game_state), 1);
      chk("restart_score", int'(score), 0);
      chk("restart_hi", int'(hi_score), 9);

      // Grace: collision held from start is ignored for two ticks.
      frames(2, 1'b0, 1'b1);
      chk("grace_state", int'(game_state), 1);
      frames(1, 1'b0, 1'b1);
      chk("grace_hit", int'(game_state), 2);
      frames(1, 1'b0, 1'b0);
      chk("grace_over", int'(game_state), 3);
      chk("grace_hi", int'(hi_score), 9);

      // Long run: speed steps and score saturation.
      goto_run();
      repeat (SCORE_DIV * 100 + GRACE - 1) apply(1'b1, 1'b0, 1'b0);
      chk("score_99", int'(score), 99);
      chk("speed_before_step", int'(speed), 4);
      apply(1'b1, 1'b0, 1'b0);
      chk("score_100", int'(score), 100);
      chk("speed_first_step", int'(speed), 5);
      repeat (SCORE_DIV * (SCORE_MAX - 100) + 60) apply(1'b1, 1'b0, 1'b0);
      chk("score_sat", int'(score), 9999);
      chk("speed_cap", int'(speed), 12);
      apply(1'b1, 1'b0, 1'b1);
      apply(1'b1, 1'b0, 1'b0);
      chk("sat_hi", int'(hi_score), 9999);

      // Random play.
      for (int i = 0; i < 4000; i++) begin
         logic b;
         b = ($urandom_range(0, 7) == 0) ? ~btn_jump : btn_jump;
         apply(($urandom_range(0, 2) == 0), b, ($urandom_range(0, 9) == 0));
      end

      // Asynchronous reset mid-game at score 57.
      goto_run();
      for (int i = 0; i < 2000 && exp_score() < 57; i++) apply(1'b1, 1'b0, 1'b0);
      chk("pre_reset_score", int'(score), 57);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk_reset_values("async");
      #3 rst = 1'b0;
      repeat (3) apply(1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      frames(20, 1'b0, 1'b0);
      chk("post_reset_run", int'(game_state), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
